// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  // addi x0, x0, 0: the canonical RV32I no-op, used for every bubble.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
    logic        fault;
  } ifid_t;

  // Reset contents of IF/ID: an empty slot with zeroed PCs.
  localparam ifid_t IFID_RESET = '{
    pc:    32'h0000_0000,
    pc4:   32'h0000_0000,
    instr: NOP_INSTR,
    valid: 1'b0,
    fault: 1'b0
  };

endpackage : fetch_pkg

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: holds one fetched entry with squash/stall control.
// Squash beats stall; an invalid load slot (fetch halted) becomes a bubble.
module ifid_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_squash,
  input  logic        i_stall,
  input  logic        i_valid,
  input  logic        i_fault,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_pc4,
  input  logic [31:0] i_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc4,
  output logic [31:0] o_instr,
  output logic        o_valid,
  output logic        o_fault
);

  ifid_t ifid_q;
  ifid_t ifid_d;

  // Next IF/ID contents: squash > stall > bubble (halted) > fetched entry.
  always_comb begin
    ifid_d = ifid_q;
    if (i_squash || (!i_stall && !i_valid)) begin
      ifid_d.pc    = i_pc;
      ifid_d.pc4   = i_pc4;
      ifid_d.instr = NOP_INSTR;
      ifid_d.valid = 1'b0;
      ifid_d.fault = 1'b0;
    end else if (!i_stall) begin
      ifid_d.pc    = i_pc;
      ifid_d.pc4   = i_pc4;
      // A faulting fetch never forwards whatever the memory returned.
      ifid_d.instr = i_fault ? NOP_INSTR : i_instr;
      ifid_d.valid = 1'b1;
      ifid_d.fault = i_fault;
    end
  end

  // Register update; reset clears to an empty slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_q <= IFID_RESET;
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign o_pc    = ifid_q.pc;
  assign o_pc4   = ifid_q.pc4;
  assign o_instr = ifid_q.instr;
  assign o_valid = ifid_q.valid;
  assign o_fault = ifid_q.fault;

endmodule : ifid_reg

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC register, fetch fault check and run/halt FSM.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   RUN   | normal fetch, PC advances by 4 each non-stalled cycle
//   HALT  | a fault was fetched; PC held, IF/ID takes bubbles until a
//         | redirect arrives
module if_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_data,
  output logic [31:0] o_ifid_pc,
  output logic [31:0] o_ifid_pc4,
  output logic [31:0] o_ifid_instr,
  output logic        o_ifid_valid,
  output logic        o_ifid_fault,
  output logic        o_halted
);

  // One bit wider than the PC so the limit itself is representable.
  localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_WORDS) * 33'd4;

  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  logic [31:0]  pc_plus4;
  fetch_state_e state_q;
  fetch_state_e state_d;
  logic         fetch_fault;
  logic         squash;

  assign pc_plus4    = pc_q + 32'd4;
  assign fetch_fault = (pc_q[1:0] != 2'b00) || ({1'b0, pc_q} >= IMEM_LIMIT);
  assign squash      = i_redirect_valid | i_flush;

  // Next PC and FSM state: redirect > stall > halt hold > sequential.
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    if (i_redirect_valid) begin
      pc_d    = i_redirect_pc;
      state_d = RUN;
    end else if (!i_stall && (state_q == RUN)) begin
      pc_d = pc_plus4;
      if (fetch_fault) begin
        state_d = HALT;
      end
    end
  end

  // PC and FSM state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      state_q <= RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  assign o_imem_addr = pc_q;
  assign o_halted    = (state_q == HALT);

  ifid_reg u_ifid_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_squash(squash),
    .i_stall (i_stall),
    .i_valid (state_q == RUN),
    .i_fault (fetch_fault),
    .i_pc    (pc_q),
    .i_pc4   (pc_plus4),
    .i_instr (i_imem_data),
    .o_pc    (o_ifid_pc),
    .o_pc4   (o_ifid_pc4),
    .o_instr (o_ifid_instr),
    .o_valid (o_ifid_valid),
    .o_fault (o_ifid_fault)
  );

endmodule : if_fetch
